prga: RTL



---
 rtl/arc4_pkg.sv | 23 ++
 rtl/prga.sv | 134 +++++++++++++
 2 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions for the init, ksa, prga stages and the arc4 top.
package arc4_pkg;

   // PRGA controller states, one per cycle of the per-byte schedule.
   typedef enum logic [3:0] {
      IDLE,
      LEN_A,
      LEN_W,
      I_A,
      J_A,
      WR_I,
      WR_J,
      PAD_A,
      PT_W
   } prga_state_t;

   // Length byte lives at address 0 of both ct and pt messages.
   localparam logic [7:0] LEN_ADDR     = 8'd0;
   localparam int         S_SIZE       = 256;
   localparam int         CYC_PER_BYTE = 6;
   localparam int         HDR_CYC      = 2;

endpackage : arc4_pkg

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: decrypts a length-prefixed ciphertext
// using the key-scheduled S array, permuting S in place as it goes.
module prga
   import arc4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] s_addr,
   input  logic [7:0] s_rddata,
   output logic [7:0] s_wrdata,
   output logic       s_wren,
   output logic [7:0] ct_addr,
   input  logic [7:0] ct_rddata,
   output logic [7:0] pt_addr,
   output logic [7:0] pt_wrdata,
   output logic       pt_wren
);

   prga_state_t state, state_nx;

   logic [7:0] i, j, k, si, sj, len;

   // State register; rst wins over everything, including en.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Datapath registers: indices, swap operands and message length.
   always_ff @(posedge clk) begin
      if (rst) begin
         i   <= '0;
         j   <= '0;
         k   <= '0;
         si  <= '0;
         sj  <= '0;
         len <= '0;
      end else begin
         case (state)
            LEN_W: begin
               len <= ct_rddata;
               if (ct_rddata != 8'd0) begin
                  k <= 8'd1;
                  i <= 8'd1;
                  j <= 8'd0;
               end
            end
            J_A: begin
               si <= s_rddata;
               j  <= j + s_rddata;       // wraps modulo 256
            end
            WR_I: sj <= s_rddata;
            PT_W: begin
               if (k != len) begin
                  k <= k + 8'd1;
                  i <= i + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and memory-port decode; every output is idle-low by default.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_nx  = state;
      rdy       = 1'b0;
      s_addr    = '0;
      s_wrdata  = '0;
      s_wren    = 1'b0;
      ct_addr   = '0;
      pt_addr   = '0;
      pt_wrdata = '0;
      pt_wren   = 1'b0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (en) state_nx = LEN_A;
         end
         LEN_A: begin
            ct_addr  = LEN_ADDR;
            state_nx = LEN_W;
         end
         LEN_W: begin
            // Echo the length into pt[0]; an empty message finishes here.
            pt_addr   = LEN_ADDR;
            pt_wrdata = ct_rddata;
            pt_wren   = 1'b1;
            state_nx  = (ct_rddata == 8'd0) ? IDLE : I_A;
         end
         I_A: begin
            s_addr   = i;
            state_nx = J_A;
         end
         J_A: begin
            // New j is needed as an address this cycle, before it is registered.
            s_addr   = j + s_rddata;
            state_nx = WR_I;
         end
         WR_I: begin
            // S[j] arrives now and goes straight into S[i]; i==j is harmless.
            s_addr   = i;
            s_wrdata = s_rddata;
            s_wren   = 1'b1;
            state_nx = WR_J;
         end
         WR_J: begin
            s_addr   = j;
            s_wrdata = si;
            s_wren   = 1'b1;
            state_nx = PAD_A;
         end
         PAD_A: begin
            s_addr   = si + sj;           // wraps modulo 256
            ct_addr  = k;
            state_nx = PT_W;
         end
         PT_W: begin
            pt_addr   = k;
            pt_wrdata = s_rddata ^ ct_rddata;
            pt_wren   = 1'b1;
            state_nx  = (k == len) ? IDLE : I_A;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule : prga
